// File: rtl/safecrack_autodialer.sv
// -----------------------------------------------------------------------------
// safecrack_autodialer
//
// Purpose:
//   Automatically dials the safecrack lock through its three active-low buttons
//   and watches the lock's LEDs to find the 3-digit code (digits 0..2).
//   A red LED at digit position k prunes the whole subtree below that prefix:
//   the digit at k is advanced (with carry into earlier digits) and all later
//   digits restart at 0. The search then replays the code from d0.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous reset, active-high
//   i_start      1-cycle pulse; starts a search when not busy
//   i_led_red    lock error LED (active-high)
//   i_led_green  lock progress LEDs {g3,g2,g1} (active-high)
//   o_btn_n      button drive, active-low, bit d low = digit d pressed
//   o_busy       search in progress
//   o_found      sticky, code opened the lock
//   o_fail       sticky, code space exhausted
//   o_fault      sticky, inconsistent lock feedback or red LED stuck high
//   o_code       {d0,d1,d2} of the opening code, valid when o_found=1
//   o_attempts   red-LED rejections this search, saturating at 31
// -----------------------------------------------------------------------------
module safecrack_autodialer #(
  parameter int PRESS_CYCLES   = 5_000_000,
  parameter int GAP_CYCLES     = 5_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_led_red,
  input  logic [2:0] i_led_green,
  output logic [2:0] o_btn_n,
  output logic       o_busy,
  output logic       o_found,
  output logic       o_fail,
  output logic       o_fault,
  output logic [5:0] o_code,
  output logic [4:0] o_attempts
);

  localparam int MAX_PG     = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int MAX_CYCLES = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] PRESS_LOAD   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_RELEASE,
    S_CHECK,
    S_WAIT_CLR,
    S_SETTLE,
    S_DONE_OK,
    S_DONE_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntLoad;
  logic [1:0]    r_digit [3];
  logic [1:0]    w_prunedDigit [3];
  logic          w_carry;
  logic [1:0]    r_pos;
  logic          r_exh;
  logic [1:0]    w_curDigit;
  logic [2:0]    w_pressMask;

  logic          w_startSearch;
  logic          w_advancePos;
  logic          w_prune;
  logic          w_latchCode;
  logic          w_setFound;
  logic          w_setFail;
  logic          w_setFault;
  logic          w_zeroPos;

  // The digit currently being dialled selects which single button goes low.
  // Outside PRESS every button is released, and since the state register is
  // cleared asynchronously, a reset releases the buttons immediately.
  always_comb begin
    case (r_pos)
      2'd0:    w_curDigit = r_digit[0];
      2'd1:    w_curDigit = r_digit[1];
      default: w_curDigit = r_digit[2];
    endcase
    w_pressMask = 3'b001 << w_curDigit;
    o_btn_n     = (r_state == S_PRESS) ? ~w_pressMask : 3'b111;
    o_busy      = (r_state != S_IDLE) && (r_state != S_DONE_OK) &&
                  (r_state != S_DONE_FAIL);
  end

  // Pruning after a red LED at position r_pos: later digits restart at 0, the
  // digit at r_pos is bumped, and a wrap from 2 back to 0 carries into the
  // earlier digit. A carry surviving past d0 means the whole space is spent.
  always_comb begin
    w_carry = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      w_prunedDigit[i] = r_digit[i];
      if (i > int'(r_pos)) begin
        w_prunedDigit[i] = 2'd0;
      end else if (w_carry) begin
        if (r_digit[i] == 2'd2) begin
          w_prunedDigit[i] = 2'd0;
        end else begin
          w_prunedDigit[i] = r_digit[i] + 2'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  // State register for the search sequencer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus one-cycle strobes that tell the datapath what to
  // update. LEDs only matter in CHECK and WAIT_CLR; every timed state leaves
  // on the cycle it sees the shared counter at zero.
  always_comb begin
    w_nextState   = r_state;
    w_startSearch = 1'b0;
    w_advancePos  = 1'b0;
    w_prune       = 1'b0;
    w_latchCode   = 1'b0;
    w_setFound    = 1'b0;
    w_setFail     = 1'b0;
    w_setFault    = 1'b0;
    w_zeroPos     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
        if (i_start) begin
          w_startSearch = 1'b1;
          w_nextState   = S_PRESS;
        end
      end
      S_PRESS: begin
        if (r_cnt == '0) w_nextState = S_RELEASE;
      end
      S_RELEASE: begin
        if (r_cnt == '0) w_nextState = S_CHECK;
      end
      S_CHECK: begin
        if (i_led_red) begin
          w_prune     = 1'b1;
          w_nextState = S_WAIT_CLR;
        end else if (r_pos != 2'd2) begin
          w_advancePos = 1'b1;
          w_nextState  = S_PRESS;
        end else if (i_led_green == 3'b111) begin
          w_latchCode = 1'b1;
          w_setFound  = 1'b1;
          w_nextState = S_DONE_OK;
        end else begin
          w_setFault  = 1'b1;
          w_nextState = S_DONE_FAIL;
        end
      end
      S_WAIT_CLR: begin
        if (!i_led_red) begin
          if (r_exh) begin
            w_setFail   = 1'b1;
            w_nextState = S_DONE_FAIL;
          end else begin
            w_zeroPos   = 1'b1;
            w_nextState = S_SETTLE;
          end
        end else if (r_cnt == '0) begin
          w_setFault  = 1'b1;
          w_nextState = S_DONE_FAIL;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_nextState = S_PRESS;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Reload value for the shared down-counter, chosen by the state being entered.
  always_comb begin
    case (w_nextState)
      S_PRESS:             w_cntLoad = PRESS_LOAD;
      S_RELEASE, S_SETTLE: w_cntLoad = GAP_LOAD;
      S_WAIT_CLR:          w_cntLoad = TIMEOUT_LOAD;
      default:             w_cntLoad = '0;
    endcase
  end

  // Datapath: the shared counter is loaded on every state change and counts
  // down otherwise; digits, position, flags and the attempt count follow the
  // strobes raised by the sequencer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_digit[0] <= 2'd0;
      r_digit[1] <= 2'd0;
      r_digit[2] <= 2'd0;
      r_pos      <= 2'd0;
      r_exh      <= 1'b0;
      o_found    <= 1'b0;
      o_fail     <= 1'b0;
      o_fault    <= 1'b0;
      o_code     <= 6'd0;
      o_attempts <= 5'd0;
    end else begin
      if (w_nextState != r_state) begin
        r_cnt <= w_cntLoad;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (w_startSearch) begin
        r_digit[0] <= 2'd0;
        r_digit[1] <= 2'd0;
        r_digit[2] <= 2'd0;
        r_pos      <= 2'd0;
        r_exh      <= 1'b0;
        o_found    <= 1'b0;
        o_fail     <= 1'b0;
        o_fault    <= 1'b0;
        o_attempts <= 5'd0;
      end

      if (w_advancePos) r_pos <= r_pos + 2'd1;
      if (w_zeroPos)    r_pos <= 2'd0;

      if (w_prune) begin
        r_digit[0] <= w_prunedDigit[0];
        r_digit[1] <= w_prunedDigit[1];
        r_digit[2] <= w_prunedDigit[2];
        r_exh      <= w_carry;
        if (o_attempts != 5'd31) o_attempts <= o_attempts + 5'd1;
      end

      if (w_latchCode) o_code  <= {r_digit[0], r_digit[1], r_digit[2]};
      if (w_setFound)  o_found <= 1'b1;
      if (w_setFail)   o_fail  <= 1'b1;
      if (w_setFault)  o_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_safecrack_autodialer.sv
// -----------------------------------------------------------------------------
// tb_safecrack_autodialer
//
// Purpose:
//   Drives safecrack_autodialer against a small behavioural model of the lock
//   (normal code, always-red, stuck-red and unresponsive variants) with short
//   press/gap/timeout lengths, and compares the results to hand-derived values.
// -----------------------------------------------------------------------------
module tb_safecrack_autodialer;

  localparam int PRESS   = 4;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 64;
  localparam int MAXWAIT = 5000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ledRed;
  logic [2:0] ledGreen;
  logic [2:0] btnN;
  logic       busy;
  logic       found;
  logic       failFlag;
  logic       faultFlag;
  logic [5:0] code;
  logic [4:0] attempts;

  int errors = 0;
  int checks = 0;

  // Lock model configuration: 0 normal, 1 always red, 2 red stuck after the
  // first press, 3 never responds.
  int         lockMode = 0;
  logic [1:0] lockCode [3];
  int         lockProg;
  int         redTimer;
  logic [2:0] prevBtn;

  // Press monitor results.
  int         pressCount = 0;
  int         badPress = 0;
  int         runLen = 0;
  logic [2:0] runPat = 3'b111;
  int         pressBase;

  safecrack_autodialer #(
    .PRESS_CYCLES  (PRESS),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_led_red  (ledRed),
    .i_led_green(ledGreen),
    .o_btn_n    (btnN),
    .o_busy     (busy),
    .o_found    (found),
    .o_fail     (failFlag),
    .o_fault    (faultFlag),
    .o_code     (code),
    .o_attempts (attempts)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lock model: reacts to a new press on the falling edge so the DUT sees
  // settled LEDs at its next rising edge. A wrong digit lights red for 20
  // cycles and throws away progress.
  always @(negedge clk) begin
    int digit;
    if (rst) begin
      lockProg = 0;
      ledRed   = 1'b0;
      ledGreen = 3'b000;
      redTimer = 0;
      prevBtn  = 3'b111;
    end else begin
      if (redTimer > 0 && lockMode != 2) begin
        redTimer = redTimer - 1;
        if (redTimer == 0) ledRed = 1'b0;
      end
      if (btnN != 3'b111 && prevBtn == 3'b111) begin
        digit = (btnN == 3'b110) ? 0 : (btnN == 3'b101) ? 1 : 2;
        case (lockMode)
          0: begin
            if (lockProg < 3) begin
              if (digit == int'(lockCode[lockProg])) begin
                ledGreen[lockProg] = 1'b1;
                lockProg = lockProg + 1;
              end else begin
                ledRed   = 1'b1;
                redTimer = 20;
                lockProg = 0;
                ledGreen = 3'b000;
              end
            end
          end
          1: begin
            ledRed   = 1'b1;
            redTimer = 20;
          end
          2: ledRed = 1'b1;
          default: ;
        endcase
      end
      prevBtn = btnN;
    end
  end

  // Press monitor: every completed press must be one button, held steady for
  // exactly PRESS cycles. Presses cut short by reset are discarded.
  always @(negedge clk) begin
    if (rst) begin
      runLen = 0;
    end else if (btnN != 3'b111) begin
      if (runLen == 0) runPat = btnN;
      else if (btnN != runPat) badPress = badPress + 1;
      runLen = runLen + 1;
    end else if (runLen != 0) begin
      pressCount = pressCount + 1;
      if (runLen != PRESS) badPress = badPress + 1;
      if ($countones(~runPat) != 1) badPress = badPress + 1;
      runLen = 0;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Configures the lock model, resets lock and DUT, then pulses start. Returns
  // on the falling edge right after the start pulse was sampled.
  task automatic applyStimulus(input int mode, input logic [1:0] c0,
                               input logic [1:0] c1, input logic [1:0] c2);
    lockMode    = mode;
    lockCode[0] = c0;
    lockCode[1] = c1;
    lockCode[2] = c2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pressBase = pressCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits, bounded, for the search to finish; optionally pulses start every
  // pulseEvery cycles while busy to show those pulses are ignored.
  task automatic waitDone(input string tag, input int pulseEvery);
    for (int n = 1; n <= MAXWAIT; n++) begin
      if (!busy) break;
      start = (pulseEvery > 0 && (n % pulseEvery) == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    ledRed   = 1'b0;
    ledGreen = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_btn", 32'(btnN), 32'h7);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_found", 32'(found), 32'd0);
    checkOutput("rst_fail", 32'(failFlag), 32'd0);
    checkOutput("rst_fault", 32'(faultFlag), 32'd0);
    checkOutput("rst_attempts", 32'(attempts), 32'd0);
    checkOutput("rst_code", 32'(code), 32'd0);

    // Code 0-1-2: three rejections, then found
    applyStimulus(0, 2'd0, 2'd1, 2'd2);
    checkOutput("t2_first_press", 32'(btnN), 32'h6);
    checkOutput("t2_busy_high", 32'(busy), 32'd1);
    waitDone("t2_done", 0);
    checkOutput("t2_found", 32'(found), 32'd1);
    checkOutput("t2_code", 32'(code), 32'h06);
    checkOutput("t2_attempts", 32'(attempts), 32'd3);
    checkOutput("t2_fail", 32'(failFlag), 32'd0);
    checkOutput("t2_btn_idle", 32'(btnN), 32'h7);
    checkOutput("t2_presses", 32'(pressCount - pressBase), 32'd11);

    // Code 2-2-2: six rejections, fifteen presses
    applyStimulus(0, 2'd2, 2'd2, 2'd2);
    waitDone("t3_done", 0);
    checkOutput("t3_found", 32'(found), 32'd1);
    checkOutput("t3_code", 32'(code), 32'h2A);
    checkOutput("t3_attempts", 32'(attempts), 32'd6);
    checkOutput("t3_presses", 32'(pressCount - pressBase), 32'd15);
    checkOutput("t3_press_shape", 32'(badPress), 32'd0);

    // Lock always rejects: d0 wraps after three attempts
    applyStimulus(1, 2'd0, 2'd0, 2'd0);
    waitDone("t4_done", 0);
    checkOutput("t4_fail", 32'(failFlag), 32'd1);
    checkOutput("t4_found", 32'(found), 32'd0);
    checkOutput("t4_fault", 32'(faultFlag), 32'd0);
    checkOutput("t4_attempts", 32'(attempts), 32'd3);

    // Red stuck high: fault after exactly TIMEOUT cycles in WAIT_CLR.
    // From the first released sample: RELEASE 4 + CHECK 1 + WAIT_CLR 64.
    applyStimulus(2, 2'd0, 2'd0, 2'd0);
    for (int k = 0; k < 20; k++) begin
      if (btnN == 3'b111) break;
      @(negedge clk);
    end
    checkOutput("t5_released", 32'(btnN), 32'h7);
    repeat (GAP + 1 + TIMEOUT - 1) @(negedge clk);
    checkOutput("t5_fault_early", 32'(faultFlag), 32'd0);
    checkOutput("t5_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("t5_fault", 32'(faultFlag), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_found", 32'(found), 32'd0);

    // Lock never responds: green incomplete at the last digit is a fault
    applyStimulus(3, 2'd0, 2'd0, 2'd0);
    waitDone("t5b_done", 0);
    checkOutput("t5b_fault", 32'(faultFlag), 32'd1);
    checkOutput("t5b_attempts", 32'(attempts), 32'd0);
    checkOutput("t5b_found", 32'(found), 32'd0);

    // Reset mid-press releases buttons at once
    applyStimulus(0, 2'd0, 2'd1, 2'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_btn", 32'(btnN), 32'h7);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start pulses while busy must not disturb the search
    applyStimulus(0, 2'd0, 2'd1, 2'd2);
    waitDone("t6_done", 23);
    checkOutput("t6_found", 32'(found), 32'd1);
    checkOutput("t6_attempts", 32'(attempts), 32'd3);
    checkOutput("t6_code", 32'(code), 32'h06);
    checkOutput("t6_presses", 32'(pressCount - pressBase), 32'd11);
    checkOutput("t6_press_shape", 32'(badPress), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
